// File: rtl/fir_controller_if.sv
// Control bundle between the sample source, the FIR sequencing controller
// and the serial-MAC datapath. The slave side is the controller; the master
// side is whatever presents samples and observes the control strobes.
interface fir_controller_if #(
    parameter int AddrWidth = 6,
    parameter int CntWidth  = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic                 shift;
    logic                 flush;
    logic [AddrWidth-1:0] address;
    logic                 out_valid;
    logic                 busy;
    logic                 drop;
    logic [CntWidth-1:0]  drop_count;

    modport master (
        output in_valid,
        input  in_ready, shift, flush, address, out_valid, busy, drop, drop_count
    );

    modport slave (
        input  in_valid,
        output in_ready, shift, flush, address, out_valid, busy, drop, drop_count
    );
endinterface

// File: rtl/fir_controller.sv
// Sequencing controller for a serial-MAC FIR datapath. One sample is taken
// in IDLE, the single multiplier is stepped over all taps in MAC, one DRAIN
// cycle lets the last product reach the accumulator, and DONE flags the one
// cycle in which the datapath output is complete. Samples offered while busy
// are counted as drops and never shifted in.
module fir_controller #(
    parameter int FIR_size  = 64,
    parameter int AddrWidth = 6,
    parameter int CntWidth  = 16
) (
    input  logic               clk,
    input  logic               rst,
    fir_controller_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MAC   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [AddrWidth-1:0] LAST_TAP  = AddrWidth'(FIR_size - 1);
    localparam logic [CntWidth-1:0]  CNT_MAX   = {CntWidth{1'b1}};

    state_t               state;
    state_t               state_nxt;
    logic [AddrWidth-1:0] cnt;
    logic [AddrWidth-1:0] cnt_nxt;
    logic                 accept;
    logic                 drop_r;
    logic [CntWidth-1:0]  drop_cnt_r;

    // Accept only in IDLE; a sample offered while reset is held is ignored.
    assign accept = bus.in_valid && (state == IDLE) && !rst;

    // State register and tap counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state and tap-counter sequencing.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = MAC;
                    cnt_nxt   = '0;
                end
            end
            MAC: begin
                if (cnt == LAST_TAP) begin
                    state_nxt = DRAIN;
                end else begin
                    cnt_nxt = cnt + AddrWidth'(1);
                end
            end
            DRAIN:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath control outputs decoded from the current state.
    always_comb begin
        bus.in_ready  = (state == IDLE);
        bus.shift     = accept;
        bus.flush     = accept;
        bus.address   = (state == MAC) ? cnt : '0;
        bus.out_valid = (state == DONE);
        bus.busy      = (state != IDLE);
    end

    // Registered drop pulse and saturating drop counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_r     <= 1'b0;
            drop_cnt_r <= '0;
        end else begin
            drop_r <= bus.in_valid && (state != IDLE);
            if (drop_r && (drop_cnt_r != CNT_MAX)) begin
                drop_cnt_r <= drop_cnt_r + CntWidth'(1);
            end
        end
    end

    assign bus.drop       = drop_r;
    assign bus.drop_count = drop_cnt_r;

endmodule

// File: tb/tb_fir_controller.sv
// Directed bench for fir_controller: a 64-tap instance for sequencing, drop
// and reset behaviour, and a 4-tap instance with a 4-bit drop counter driving
// a small behavioural serial-MAC datapath for back-to-back and saturation.
module tb_fir_controller;

    logic clk;
    logic rst;

    int tests;
    int fails;

    fir_controller_if #(.AddrWidth(6), .CntWidth(16)) b64 ();
    fir_controller_if #(.AddrWidth(2), .CntWidth(4))  b4 ();

    fir_controller #(.FIR_size(64), .AddrWidth(6), .CntWidth(16)) u_dut64 (
        .clk (clk),
        .rst (rst),
        .bus (b64.slave)
    );

    fir_controller #(.FIR_size(4), .AddrWidth(2), .CntWidth(4)) u_dut4 (
        .clk (clk),
        .rst (rst),
        .bus (b4.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural serial-MAC datapath for the 4-tap instance.
    int din;
    int x [4];
    int coef [4];
    int prod;
    int acc;

    initial begin
        coef[0] = 3;
        coef[1] = 5;
        coef[2] = 7;
        coef[3] = 11;
    end

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) x[i] <= 0;
            prod <= 0;
            acc  <= 0;
        end else begin
            if (b4.shift) begin
                x[0] <= din;
                x[1] <= x[0];
                x[2] <= x[1];
                x[3] <= x[2];
            end
            if (b4.flush) begin
                prod <= 0;
                acc  <= 0;
            end else begin
                prod <= coef[b4.address] * x[b4.address];
                acc  <= acc + prod;
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Exact single-sample sequence on the 64-tap instance; cycle 0 = accept.
    task automatic run_single(input string tag);
        int exp_addr;
        b64.in_valid = 1'b1;
        for (int c = 0; c <= 70; c++) begin
            @(negedge clk);
            exp_addr = (c >= 1 && c <= 64) ? c - 1 : 0;
            tests++;
            if (b64.shift !== (c == 0)) begin
                fails++;
                $display("FAIL %s shift c=%0d: got %b expected %b", tag, c, b64.shift, (c == 0));
            end
            tests++;
            if (b64.flush !== (c == 0)) begin
                fails++;
                $display("FAIL %s flush c=%0d: got %b expected %b", tag, c, b64.flush, (c == 0));
            end
            tests++;
            if (b64.address !== 6'(exp_addr)) begin
                fails++;
                $display("FAIL %s address c=%0d: got %0d expected %0d", tag, c, b64.address, exp_addr);
            end
            tests++;
            if (b64.out_valid !== (c == 66)) begin
                fails++;
                $display("FAIL %s out_valid c=%0d: got %b expected %b", tag, c, b64.out_valid, (c == 66));
            end
            tests++;
            if (b64.in_ready !== (c == 0 || c >= 67)) begin
                fails++;
                $display("FAIL %s in_ready c=%0d: got %b expected %b", tag, c, b64.in_ready, (c == 0 || c >= 67));
            end
            tests++;
            if (b64.busy !== (c >= 1 && c <= 66)) begin
                fails++;
                $display("FAIL %s busy c=%0d: got %b expected %b", tag, c, b64.busy, (c >= 1 && c <= 66));
            end
            @(posedge clk); #1;
            b64.in_valid = 1'b0;
        end
    endtask

    task automatic test_reset();
        #2;
        rst = 1'b1;
        #1;
        tests++;
        if (b64.in_ready !== 1'b1 || b64.shift !== 1'b0 || b64.flush !== 1'b0) begin
            fails++;
            $display("FAIL reset_hs: got rdy=%b sh=%b fl=%b expected 1 0 0", b64.in_ready, b64.shift, b64.flush);
        end
        tests++;
        if (b64.address !== 6'd0 || b64.out_valid !== 1'b0 || b64.busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_ctl: got addr=%0d ov=%b busy=%b expected 0 0 0", b64.address, b64.out_valid, b64.busy);
        end
        tests++;
        if (b64.drop !== 1'b0 || b64.drop_count !== 16'd0) begin
            fails++;
            $display("FAIL reset_drop: got drop=%b cnt=%0d expected 0 0", b64.drop, b64.drop_count);
        end
        tests++;
        if (b4.in_ready !== 1'b1 || b4.drop_count !== 4'd0 || b4.busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_b4: got rdy=%b cnt=%0d busy=%b expected 1 0 0", b4.in_ready, b4.drop_count, b4.busy);
        end
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_single();
        run_single("single");
    endtask

    task automatic test_drop();
        int exp_cnt;
        b64.in_valid = 1'b1;
        for (int c = 0; c <= 70; c++) begin
            @(negedge clk);
            exp_cnt = (c < 3) ? 0 : ((c - 2 > 10) ? 10 : c - 2);
            if (c >= 1) begin
                tests++;
                if (b64.shift !== 1'b0) begin
                    fails++;
                    $display("FAIL drop_shift c=%0d: got %b expected 0", c, b64.shift);
                end
            end
            tests++;
            if (b64.drop !== (c >= 2 && c <= 11)) begin
                fails++;
                $display("FAIL drop_pulse c=%0d: got %b expected %b", c, b64.drop, (c >= 2 && c <= 11));
            end
            tests++;
            if (b64.drop_count !== 16'(exp_cnt)) begin
                fails++;
                $display("FAIL drop_count c=%0d: got %0d expected %0d", c, b64.drop_count, exp_cnt);
            end
            @(posedge clk); #1;
            b64.in_valid = (c + 1 <= 10);
        end
        tests++;
        if (b64.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL drop_idle: got %b expected 1", b64.in_ready);
        end
    endtask

    task automatic test_back_to_back();
        int samp [5];
        int expo [5];
        int k;
        samp = '{1, 0, 0, 0, 0};
        expo = '{3, 5, 7, 11, 0};
        do_reset();
        k = 0;
        for (int c = 0; c <= 40; c++) begin
            b4.in_valid = (k < 5);
            din = (k < 5) ? samp[k] : 0;
            @(negedge clk);
            tests++;
            if (b4.shift !== ((c % 7 == 0) && k < 5)) begin
                fails++;
                $display("FAIL b2b_accept c=%0d: got %b expected %b", c, b4.shift, ((c % 7 == 0) && k < 5));
            end
            tests++;
            if (b4.out_valid !== ((c % 7 == 6) && c <= 34)) begin
                fails++;
                $display("FAIL b2b_out_valid c=%0d: got %b expected %b", c, b4.out_valid, ((c % 7 == 6) && c <= 34));
            end
            if ((c % 7 == 6) && c <= 34) begin
                tests++;
                if (acc !== expo[(c - 6) / 7]) begin
                    fails++;
                    $display("FAIL b2b_dout c=%0d: got %0d expected %0d", c, acc, expo[(c - 6) / 7]);
                end
            end
            if (c % 7 == 0) k++;
            @(posedge clk); #1;
        end
        b4.in_valid = 1'b0;
    endtask

    task automatic test_saturation();
        int ev;
        int exp_cnt;
        logic exp_drop;
        logic ev_now;
        do_reset();
        ev = 0;
        exp_cnt = 0;
        exp_drop = 1'b0;
        for (int c = 0; c < 40; c++) begin
            b4.in_valid = (ev < 20);
            ev_now = (ev < 20) && (c % 7 != 0);
            @(negedge clk);
            tests++;
            if (b4.drop !== exp_drop) begin
                fails++;
                $display("FAIL sat_drop c=%0d: got %b expected %b", c, b4.drop, exp_drop);
            end
            tests++;
            if (b4.drop_count !== 4'(exp_cnt)) begin
                fails++;
                $display("FAIL sat_count c=%0d: got %0d expected %0d", c, b4.drop_count, exp_cnt);
            end
            if (exp_drop && exp_cnt < 15) exp_cnt++;
            exp_drop = ev_now;
            if (ev_now) ev++;
            @(posedge clk); #1;
        end
        b4.in_valid = 1'b0;
        tests++;
        if (b4.drop_count !== 4'd15) begin
            fails++;
            $display("FAIL sat_final: got %0d expected 15", b4.drop_count);
        end
    endtask

    task automatic test_mid_reset();
        int bad_ov;
        do_reset();
        b64.in_valid = 1'b1;
        for (int c = 0; c <= 31; c++) begin
            @(negedge clk);
            if (c == 31) begin
                tests++;
                if (b64.address !== 6'd30) begin
                    fails++;
                    $display("FAIL midrst_addr: got %0d expected 30", b64.address);
                end
            end else begin
                @(posedge clk); #1;
                b64.in_valid = 1'b0;
            end
        end
        rst = 1'b1;
        #1;
        tests++;
        if (b64.busy !== 1'b0 || b64.in_ready !== 1'b1 || b64.address !== 6'd0) begin
            fails++;
            $display("FAIL midrst_abort: got busy=%b rdy=%b addr=%0d expected 0 1 0", b64.busy, b64.in_ready, b64.address);
        end
        tests++;
        if (b4.drop_count !== 4'd0) begin
            fails++;
            $display("FAIL midrst_cnt: got %0d expected 0", b4.drop_count);
        end
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        bad_ov = 0;
        for (int c = 0; c < 70; c++) begin
            @(negedge clk);
            if (b64.out_valid !== 1'b0 || b64.busy !== 1'b0) bad_ov++;
            @(posedge clk); #1;
        end
        tests++;
        if (bad_ov != 0) begin
            fails++;
            $display("FAIL midrst_no_output: got %0d active cycles expected 0", bad_ov);
        end
        run_single("after_reset");
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b0;
        din = 0;
        b64.in_valid = 1'b0;
        b4.in_valid = 1'b0;
        test_reset();
        test_single();
        test_drop();
        test_back_to_back();
        test_saturation();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got no completion expected finish before limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fir_controller.md
# fir_controller

Sequencing controller for the serial-MAC FIR datapath. It accepts input samples over a valid/ready handshake and drives the datapath's `shift`, `flush` and `address` inputs. It steps the single multiplier through all `FIR_size` taps and flags the one cycle in which the datapath accumulator holds the finished output sample. It sits between the sample source and the datapath, which consumes exactly the control signals this block produces.

## Interface
- `FIR_size`, 64, number of taps (≥2); one MAC cycle per tap.
- `AddrWidth`, 6, width of `address`; must satisfy 2^AddrWidth ≥ FIR_size.
- `CntWidth`, 16, width of the `drop_count` saturating counter.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  a sample is present on the datapath's `din`.
- `in_ready`  out  1  controller can take a sample this cycle.
- `shift`  out  1  datapath shift-register load strobe.
- `flush`  out  1  datapath clear of product and accumulator registers.
- `address`  out  AddrWidth  tap/coefficient select.
- `out_valid`  out  1  the datapath `dout` holds a complete output sample this cycle.
- `busy`  out  1  high in any state other than IDLE.
- `drop`  out  1  one-cycle pulse: `in_valid` was high while `in_ready` was low.
- `drop_count`  out  CntWidth  count of `drop` events; saturates at all-ones.

## Operation
- The FSM has four states: IDLE, MAC, DRAIN, DONE. A tap counter `cnt` (AddrWidth bits) runs alongside it.
- **IDLE:**
  - `in_ready=1`, `address=0`.
  - On `in_valid`: `shift=1` and `flush=1` in the same cycle (combinational, equal to `in_valid & in_ready`).
  - Then `cnt←0` and go to MAC.
- **MAC:**
  - `address=cnt`.
  - If `cnt==FIR_size-1`, go to DRAIN. Otherwise `cnt←cnt+1`.
- **DRAIN:** one cycle; `address=0`. The final product is accumulated at the end of this cycle. Go to DONE.
- **DONE:** one cycle; `out_valid=1`, `address=0`. Go to IDLE.
- `in_ready` is 0 in MAC, DRAIN and DONE.
  - In DONE this is mandatory, because accepting a sample there would flush `dout` while it is being presented.
- `shift` and `flush` are never asserted outside the IDLE accept cycle.
- `out_valid` has no backpressure. The sink must capture `dout` in the DONE cycle, because the datapath accumulator keeps integrating afterwards.
- **Drop tracking:**
  - `drop = in_valid & ~in_ready`, registered, so it pulses in the cycle after the event.
  - `drop_count` increments on every `drop` pulse and holds at 2^CntWidth−1.
  - Dropped samples are never shifted in.
- `busy = (state != IDLE)`.

## Timing
- **Reset (asynchronous):**
  - State←IDLE, `cnt←0`, `drop←0`, `drop_count←0`.
  - Therefore `in_ready=1`, `shift=flush=0` (while `in_valid` is low), `address=0`, `out_valid=0`, `busy=0`.
- **Reset asserted mid-operation:** the sample is abandoned immediately. No `out_valid` is produced for it.
- **`in_valid` while `rst` is high:** ignored.
- **Per-sample sequence** (cycle 0 = accept cycle in IDLE):
  - cycles 1..FIR_size: MAC, with `address` = 0..FIR_size−1.
  - cycle FIR_size+1: DRAIN.
  - cycle FIR_size+2: DONE, with `out_valid=1`.
  - cycle FIR_size+3: IDLE, with `in_ready=1`.
- Latency from accept to `out_valid` is FIR_size+2 cycles. Maximum throughput is one sample per FIR_size+3 cycles.
- **Datapath assumptions the sequence relies on:**
  - 1-cycle product register, then the accumulator register.
  - `flush` in cycle 0 zeroes both, so MAC cycle 1 adds 0.
  - The accumulator holds the full sum in exactly cycle FIR_size+2.
- `in_valid` held high continuously: a new sample is accepted on every IDLE cycle. The `drop` pulse then repeats for each of the FIR_size+2 busy cycles in which it is high.

## Test plan
- **Reset and idle:**
  - Stimulus: assert `rst` mid-cycle with no clock edge.
  - Required: all outputs at the reset values immediately; `in_ready=1`, `address=0`, `drop_count=0`.
- **Single sample, FIR_size=64:**
  - Stimulus: pulse `in_valid` at cycle 0.
  - Required: `shift=flush=1` only in cycle 0; `address` ramps 0..63 over cycles 1..64; `out_valid=1` only in cycle 66; `in_ready` returns to 1 in cycle 67.
- **Back-to-back, with the datapath, FIR_size=4:**
  - Stimulus: hold `in_valid` high with samples 1, 0, 0, 0, 0.
  - Required: accepts every 7 cycles; first output `dout=coeffs[0]`, second `dout=coeffs[1]`.
- **Drop counting:**
  - Stimulus: assert `in_valid` during cycles 1..10 of a MAC run.
  - Required: ten `drop` pulses; `drop_count=10`; no extra `shift`.
- **Saturation, CntWidth=4:**
  - Stimulus: produce 20 drop events.
  - Required: `drop_count` stops at 15.
- **Mid-operation reset:**
  - Stimulus: assert `rst` at MAC `address=30`; release, then send a new sample.
  - Required: no `out_valid` for the aborted sample; the new sample follows the exact single-sample sequence.
